iic_cmd_queue: RTL and testbench

- Command buffer and sequencer that sits directly upstream of iic_driver.
- Accepts register read/write commands from the MCU/control logic over a valid/ready interface and buffers them in a FIFO.
- Issues the commands one at a time on the reg_iic_* interface, waits for reg_iic_done, and returns a response (read data or timeout flag) per command.
- Enforces a minimum bus-idle gap between transactions.

---
 rtl/iic_cmd_queue.sv | 270 +++++++++++++++++++++++++++
 tb/tb_iic_cmd_queue.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_cmd_queue.sv
// -----------------------------------------------------------------------------
// iic_cmd_queue
//
// Command buffer and sequencer placed directly upstream of iic_driver.
// Register read/write commands arrive over a valid/ready interface and are
// buffered in a FIFO. They are issued one at a time on the reg_iic_*
// interface. The block waits for reg_iic_done, or for a timeout, then returns
// one response strobe per command. A programmable idle gap is enforced
// between the end of one transaction and the next request.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake (ready = FIFO not full)
//   cmd_whrl            1 = write, 0 = read
//   cmd_dev_addr        7-bit I2C device address
//   cmd_addr            8-bit register address
//   cmd_wdata           write data (ignored for reads)
//   soft_clr            level: flush pending FIFO entries
//   rsp_valid           one-cycle response strobe (no backpressure)
//   rsp_whrl            whrl of the completed command
//   rsp_rdata           read data; 0 for writes and timeouts
//   rsp_timeout         qualifies rsp_valid: transaction timed out
//   fifo_level          number of pending FIFO entries
//   busy                FSM not idle or FIFO not empty
//   reg_iic_*           command fields and one-cycle req pulse to iic_driver
//   reg_iic_rdata/done  read data and completion pulse from iic_driver
//
// Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module iic_cmd_queue #(
  parameter int FIFO_DEPTH     = 8,        // power of 2, >= 2
  parameter int GAP_CYCLES     = 100,      // idle cycles after each response, >= 1
  parameter int TIMEOUT_CYCLES = 2000000,  // WAIT cycles before a timeout response
  parameter int CNT_W          = 24        // must hold TIMEOUT_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_whrl,
  input  logic [6:0]                  cmd_dev_addr,
  input  logic [7:0]                  cmd_addr,
  input  logic [7:0]                  cmd_wdata,
  input  logic                        soft_clr,
  output logic                        rsp_valid,
  output logic                        rsp_whrl,
  output logic [7:0]                  rsp_rdata,
  output logic                        rsp_timeout,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy,
  output logic                        reg_iic_whrl,
  output logic [6:0]                  reg_iic_dev_addr,
  output logic [7:0]                  reg_iic_addr,
  output logic [7:0]                  reg_iic_wdata,
  output logic                        reg_iic_req,
  input  logic [7:0]                  reg_iic_rdata,
  input  logic                        reg_iic_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  // The timeout response is registered on the edge where the counter steps
  // to TIMEOUT_CYCLES-1. That places rsp_valid exactly TIMEOUT_CYCLES cycles
  // after the req pulse.
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES >= 2) ? (TIMEOUT_CYCLES - 2) : 0);

  typedef struct packed {
    logic       whrl;
    logic [6:0] dev_addr;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_WAIT,
    S_GAP
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  cmd_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  cmd_t             head_q, head_d;    // entry popped in IDLE, consumed by LOAD
  cmd_t             issue_q, issue_d;  // fields presented to iic_driver

  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;
  logic             req_q, req_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_whrl_q, rsp_whrl_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic             rsp_timeout_q, rsp_timeout_d;

  logic             push;
  logic             pop;
  cmd_t             push_data;

  assign push_data = '{whrl: cmd_whrl, dev_addr: cmd_dev_addr,
                       addr: cmd_addr, wdata: cmd_wdata};

  // soft_clr drops a push presented in the same cycle.
  assign push = cmd_valid & cmd_ready_q & ~soft_clr;
  // A pop is taken while flushing too: the popped entry is already in flight.
  assign pop  = (state_q == S_IDLE) && (level_q != '0);

  // ---------------------------------------------------------------------------
  // FIFO pointers and level
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: each variable driven here gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (soft_clr) begin
      // Discard everything pending by catching the read pointer up.
      rd_ptr_d = wr_ptr_q;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    end
  end

  // NOTE: the storage array has no reset. Its contents are only read behind
  // a non-zero level, so it does not need one, and leaving it out keeps it a
  // plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // ---------------------------------------------------------------------------
  // Sequencer: next state and registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    head_d        = head_q;
    issue_d       = issue_q;
    req_d         = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_whrl_d    = 1'b0;
    rsp_rdata_d   = 8'h00;
    rsp_timeout_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          head_d  = mem_q[rd_ptr_q];
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        // The issue registers change only here and hold through REQ/WAIT/GAP.
        issue_d = head_q;
        req_d   = 1'b1;
        state_d = S_REQ;
      end

      S_REQ: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // done is checked first, so it wins over the terminal count.
        if (reg_iic_done) begin
          rsp_valid_d = 1'b1;
          rsp_whrl_d  = issue_q.whrl;
          rsp_rdata_d = issue_q.whrl ? 8'h00 : reg_iic_rdata;
          cnt_d       = '0;
          state_d     = S_GAP;
        end else if (cnt_q == TO_LAST) begin
          rsp_valid_d   = 1'b1;
          rsp_whrl_d    = issue_q.whrl;
          rsp_timeout_d = 1'b1;
          cnt_d         = '0;
          state_d       = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // ready and busy are registered from next-state values. That gives them
    // the same timing a combinational decode of the current state would have.
    cmd_ready_d = (level_d != LVL_FULL);
    busy_d      = (state_d != S_IDLE) || (level_d != '0);
  end

  // NOTE: sequential state uses non-blocking assignments. Every flop then
  // samples pre-edge values, independent of process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      head_q        <= '0;
      issue_q       <= '0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      req_q         <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_whrl_q    <= 1'b0;
      rsp_rdata_q   <= 8'h00;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      head_q        <= head_d;
      issue_q       <= issue_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      req_q         <= req_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_whrl_q    <= rsp_whrl_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cmd_ready        = cmd_ready_q;
  assign fifo_level       = level_q;
  assign busy             = busy_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_whrl         = rsp_whrl_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign rsp_timeout      = rsp_timeout_q;
  assign reg_iic_req      = req_q;
  assign reg_iic_whrl     = issue_q.whrl;
  assign reg_iic_dev_addr = issue_q.dev_addr;
  assign reg_iic_addr     = issue_q.addr;
  assign reg_iic_wdata    = issue_q.wdata;

endmodule

// File: tb/tb_iic_cmd_queue.sv
module tb_iic_cmd_queue;

  localparam int FIFO_DEPTH     = 8;
  localparam int GAP_CYCLES     = 10;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int CNT_W          = 24;
  localparam int LVL_W          = $clog2(FIFO_DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_whrl;
  logic [6:0]       cmd_dev_addr;
  logic [7:0]       cmd_addr;
  logic [7:0]       cmd_wdata;
  logic             soft_clr;
  logic             rsp_valid;
  logic             rsp_whrl;
  logic [7:0]       rsp_rdata;
  logic             rsp_timeout;
  logic [LVL_W-1:0] fifo_level;
  logic             busy;
  logic             reg_iic_whrl;
  logic [6:0]       reg_iic_dev_addr;
  logic [7:0]       reg_iic_addr;
  logic [7:0]       reg_iic_wdata;
  logic             reg_iic_req;
  logic [7:0]       reg_iic_rdata;
  logic             reg_iic_done;

  iic_cmd_queue #(
    .FIFO_DEPTH    (FIFO_DEPTH),
    .GAP_CYCLES    (GAP_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_whrl        (cmd_whrl),
    .cmd_dev_addr    (cmd_dev_addr),
    .cmd_addr        (cmd_addr),
    .cmd_wdata       (cmd_wdata),
    .soft_clr        (soft_clr),
    .rsp_valid       (rsp_valid),
    .rsp_whrl        (rsp_whrl),
    .rsp_rdata       (rsp_rdata),
    .rsp_timeout     (rsp_timeout),
    .fifo_level      (fifo_level),
    .busy            (busy),
    .reg_iic_whrl    (reg_iic_whrl),
    .reg_iic_dev_addr(reg_iic_dev_addr),
    .reg_iic_addr    (reg_iic_addr),
    .reg_iic_wdata   (reg_iic_wdata),
    .reg_iic_req     (reg_iic_req),
    .reg_iic_rdata   (reg_iic_rdata),
    .reg_iic_done    (reg_iic_done)
  );

  always #5 clk = ~clk;

  // Cycle index: during cycle k (between edges k and k+1), cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       whrl;
    logic [6:0] dev;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  typedef struct {
    int         delay;   // cycles from req to done
    bit         never;   // driver never answers
    logic [7:0] rdata;
  } drv_t;

  typedef struct {
    logic       whrl;
    logic [7:0] rdata;
    logic       timeout;
  } rsp_t;

  typedef struct {
    cmd_t cmd;
    drv_t drv;
    rsp_t exp;
  } vec_t;

  cmd_t exp_cmd_q[$];
  drv_t drv_q[$];
  rsp_t exp_rsp_q[$];

  int   n_vec = 0;
  int   n_err = 0;

  int   req_count     = 0;
  int   rsp_count     = 0;
  int   last_req_cyc  = 0;
  int   last_rsp_cyc  = 0;
  int   last_done_cyc = 0;
  bit   have_rsp      = 0;
  bit   spur_req      = 0;
  logic [7:0] issued_addr = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [6:0] dv, input logic [7:0] ad,
                              input logic [7:0] wd, input int dly, input bit nev,
                              input logic [7:0] drd, input logic [7:0] erd, input logic eto);
    vec_t v;
    v.cmd.whrl    = w;
    v.cmd.dev     = dv;
    v.cmd.addr    = ad;
    v.cmd.wdata   = wd;
    v.drv.delay   = dly;
    v.drv.never   = nev;
    v.drv.rdata   = drd;
    v.exp.whrl    = w;
    v.exp.rdata   = erd;
    v.exp.timeout = eto;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // iic_driver model: answers each req from the drv_q script
  // ---------------------------------------------------------------------------
  initial begin
    drv_t d;
    reg_iic_done  = 1'b0;
    reg_iic_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && reg_iic_req && drv_q.size() != 0) begin
        d = drv_q.pop_front();
        if (!d.never) begin
          repeat (d.delay) @(negedge clk);
          reg_iic_rdata = d.rdata;
          reg_iic_done  = 1'b1;
          last_done_cyc = cyc;
          @(negedge clk);
          reg_iic_done  = 1'b0;
          reg_iic_rdata = 8'h00;
        end
      end else if (spur_req) begin
        spur_req      = 0;
        reg_iic_rdata = 8'hBD;
        reg_iic_done  = 1'b1;
        @(negedge clk);
        reg_iic_done  = 1'b0;
        reg_iic_rdata = 8'h00;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin
    cmd_t c;
    rsp_t e;
    logic prev_req = 1'b0;
    logic prev_rsp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (reg_iic_req) begin
          req_count++;
          check("req_one_cycle", prev_req, 1'b0);
          if (have_rsp) check("req_gap", (cyc - last_rsp_cyc) >= GAP_CYCLES + 2, 1'b1);
          check("req_expected", exp_cmd_q.size() != 0, 1'b1);
          if (exp_cmd_q.size() != 0) begin
            c = exp_cmd_q.pop_front();
            check("req_whrl", reg_iic_whrl, c.whrl);
            check("req_dev", reg_iic_dev_addr, c.dev);
            check("req_addr", reg_iic_addr, c.addr);
            check("req_wdata", reg_iic_wdata, c.wdata);
            issued_addr = c.addr;
          end
          last_req_cyc = cyc;
        end
        if (rsp_valid) begin
          rsp_count++;
          check("rsp_one_cycle", prev_rsp, 1'b0);
          check("rsp_expected", exp_rsp_q.size() != 0, 1'b1);
          if (exp_rsp_q.size() != 0) begin
            e = exp_rsp_q.pop_front();
            check("rsp_whrl", rsp_whrl, e.whrl);
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_timeout", rsp_timeout, e.timeout);
            if (e.timeout) check("timeout_latency", cyc - last_req_cyc, TIMEOUT_CYCLES);
            else           check("done_latency", cyc - last_done_cyc, 1);
            check("addr_held", reg_iic_addr, issued_addr);
          end
          last_rsp_cyc = cyc;
          have_rsp     = 1;
        end
      end
      prev_req = reg_iic_req;
      prev_rsp = rsp_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at a negedge, return at a negedge)
  // ---------------------------------------------------------------------------
  task automatic push_cmd(input vec_t v, output int acc);
    int guard = 0;
    cmd_valid    = 1'b1;
    cmd_whrl     = v.cmd.whrl;
    cmd_dev_addr = v.cmd.dev;
    cmd_addr     = v.cmd.addr;
    cmd_wdata    = v.cmd.wdata;
    while (!cmd_ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("push_ready", cmd_ready, 1'b1);
    acc = cyc + 1;
    if (cmd_ready) begin
      exp_cmd_q.push_back(v.cmd);
      drv_q.push_back(v.drv);
      exp_rsp_q.push_back(v.exp);
    end
    @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_rsp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_rsp_q.size(), 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle", busy, 1'b0);
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    int r0 = req_count;
    while (req_count == r0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", req_count != r0, 1'b1);
  endtask

  task automatic check_reset_state(input string p);
    check({p, "_cmd_ready"}, cmd_ready, 1'b1);
    check({p, "_rsp_valid"}, rsp_valid, 1'b0);
    check({p, "_rsp_misc"}, {rsp_whrl, rsp_timeout, rsp_rdata}, '0);
    check({p, "_level"}, fifo_level, '0);
    check({p, "_busy"}, busy, 1'b0);
    check({p, "_req"}, reg_iic_req, 1'b0);
    check({p, "_iic_fields"}, {reg_iic_whrl, reg_iic_dev_addr, reg_iic_addr, reg_iic_wdata}, '0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    vec_t vecs[$];
    vec_t v;
    int   acc;
    int   r0;
    int   s0;

    rst          = 1'b1;
    cmd_valid    = 1'b0;
    cmd_whrl     = 1'b0;
    cmd_dev_addr = 7'h00;
    cmd_addr     = 8'h00;
    cmd_wdata    = 8'h00;
    soft_clr     = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    rst = 1'b0;
    @(negedge clk);

    // whrl dev addr wdata | delay never drv_rdata | exp_rdata exp_timeout
    vecs.push_back(mk(1'b1, 7'h68, 8'h28, 8'hA5,  500, 1'b0, 8'hEE, 8'h00, 1'b0));
    vecs.push_back(mk(1'b0, 7'h68, 8'h75, 8'h00,   20, 1'b0, 8'h3C, 8'h3C, 1'b0));
    vecs.push_back(mk(1'b0, 7'h50, 8'h01, 8'h11,    1, 1'b0, 8'h81, 8'h81, 1'b0));
    vecs.push_back(mk(1'b0, 7'h50, 8'h02, 8'h00,    0, 1'b1, 8'h00, 8'h00, 1'b1));
    vecs.push_back(mk(1'b1, 7'h1A, 8'hFF, 8'h00,  999, 1'b0, 8'h55, 8'h00, 1'b0));
    vecs.push_back(mk(1'b0, 7'h1A, 8'h10, 8'h00,  999, 1'b0, 8'hC3, 8'hC3, 1'b0));
    vecs.push_back(mk(1'b0, 7'h1A, 8'h11, 8'h00, 1000, 1'b0, 8'h99, 8'h00, 1'b1));
    vecs.push_back(mk(1'b1, 7'h7F, 8'h00, 8'h5A,    3, 1'b0, 8'h77, 8'h00, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      wait_idle(3000);
      push_cmd(vecs[i], acc);
      cmd_valid = 1'b0;
      wait_drain(3000);
      check("req_latency", last_req_cyc - acc, 2);
    end
    wait_idle(3000);

    // Fill with the driver slow: 9 back-to-back, first pops, 8 remain.
    for (int i = 0; i < 9; i++) begin
      logic [7:0] ii;
      ii = 8'(i);
      v  = mk(ii[0], 7'h20 + 7'(i), 8'h40 + ii, ii * 8'd3, 50, 1'b0,
              8'h90 + ii, ii[0] ? 8'h00 : 8'h90 + ii, 1'b0);
      push_cmd(v, acc);
    end
    cmd_addr = 8'hEE;  // 10th command held on a full FIFO, never accepted
    check("full_level", fifo_level, 8);
    check("full_ready", cmd_ready, 1'b0);
    repeat (5) @(negedge clk);
    check("stall_level", fifo_level, 8);
    check("stall_busy", busy, 1'b1);
    cmd_valid = 1'b0;
    wait_drain(5000);
    wait_idle(3000);

    // Timeout followed by a queued command.
    push_cmd(mk(1'b0, 7'h33, 8'h44, 8'h00, 0, 1'b1, 8'h00, 8'h00, 1'b1), acc);
    push_cmd(mk(1'b1, 7'h33, 8'h45, 8'h6B, 5, 1'b0, 8'h12, 8'h00, 1'b0), acc);
    cmd_valid = 1'b0;
    wait_drain(3000);
    wait_idle(3000);

    // soft_clr with 3 pending entries while a transaction is in WAIT.
    push_cmd(mk(1'b0, 7'h0C, 8'h21, 8'h00, 200, 1'b0, 8'h42, 8'h42, 1'b0), acc);
    cmd_valid = 1'b0;
    wait_req(100);
    for (int i = 0; i < 3; i++) begin
      push_cmd(mk(1'b1, 7'h0D, 8'(i), 8'hC0, 5, 1'b0, 8'h00, 8'h00, 1'b0), acc);
    end
    cmd_valid = 1'b0;
    check("clr_pre_level", fifo_level, 3);
    soft_clr  = 1'b1;
    cmd_valid = 1'b1;  // push in the flush cycle is dropped
    cmd_addr  = 8'hDD;
    @(negedge clk);
    soft_clr  = 1'b0;
    cmd_valid = 1'b0;
    check("clr_level", fifo_level, 0);
    check("clr_ready", cmd_ready, 1'b1);
    exp_cmd_q.delete();
    drv_q.delete();
    while (exp_rsp_q.size() > 1) exp_rsp_q.delete(exp_rsp_q.size() - 1);
    r0 = req_count;
    wait_drain(500);
    repeat (GAP_CYCLES + 20) @(negedge clk);
    check("clr_no_req", req_count, r0);
    check("clr_idle", busy, 1'b0);

    // done outside WAIT is ignored.
    s0 = rsp_count;
    spur_req = 1;
    repeat (20) @(negedge clk);
    check("spur_no_rsp", rsp_count, s0);
    check("spur_idle", busy, 1'b0);

    // Reset mid-transaction, then normal operation.
    push_cmd(mk(1'b0, 7'h55, 8'h66, 8'h00, 0, 1'b1, 8'h00, 8'h00, 1'b1), acc);
    cmd_valid = 1'b0;
    wait_req(100);
    push_cmd(mk(1'b1, 7'h55, 8'h67, 8'h01, 5, 1'b0, 8'h00, 8'h00, 1'b0), acc);
    push_cmd(mk(1'b1, 7'h55, 8'h68, 8'h02, 5, 1'b0, 8'h00, 8'h00, 1'b0), acc);
    cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("prerst_level", fifo_level, 2);
    s0 = rsp_count;
    #2 rst = 1'b1;
    #1 check_reset_state("async_rst");
    exp_cmd_q.delete();
    drv_q.delete();
    exp_rsp_q.delete();
    have_rsp = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (TIMEOUT_CYCLES + 50) @(negedge clk);
    check("rst_no_rsp", rsp_count, s0);
    push_cmd(mk(1'b0, 7'h2B, 8'h0F, 8'h00, 7, 1'b0, 8'hA7, 8'hA7, 1'b0), acc);
    cmd_valid = 1'b0;
    wait_drain(500);
    check("post_rst_latency", last_req_cyc - acc, 2);
    wait_idle(500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule
